// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache miss ports onto one memory port, serving one request at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration. By default, D has fixed priority over I.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              arb_busy
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t state;
    logic   d_req;
    logic   d_win;

    assign d_req = d_read | d_write;

`ifdef MEM_ARB_RR_EN
    // prio_d set: D wins a tie. The flag flips toward the side that was not just granted.
    logic prio_d;
    assign d_win = d_req & (prio_d | ~i_read);
`else
    assign d_win = d_req;
`endif

    // mem_read/mem_write act as the latched op. They are only written on grant and on completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
`ifdef MEM_ARB_RR_EN
            prio_d      <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (d_win) begin
                        state       <= SERVE_D;
                        mem_address <= d_address;
                        mem_wdata   <= d_wdata;
                        mem_write   <= d_write;
                        mem_read    <= ~d_write;
`ifdef MEM_ARB_RR_EN
                        prio_d      <= 1'b0;
`endif
                    end else if (i_read) begin
                        state       <= SERVE_I;
                        mem_address <= i_address;
                        mem_read    <= 1'b1;
                        mem_write   <= 1'b0;
`ifdef MEM_ARB_RR_EN
                        prio_d      <= 1'b1;
`endif
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign arb_busy = (state != IDLE);
    assign i_resp   = rst & (state == SERVE_I) & mem_resp;
    assign d_resp   = rst & (state == SERVE_D) & mem_resp;
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

`ifndef SYNTHESIS
    a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));
    a_resp_idle: assert property (@(posedge clk) disable iff (!rst) !(state == IDLE && mem_resp));
    a_strb_excl: assert property (@(posedge clk) disable iff (!rst) !(mem_read && mem_write));
`endif

endmodule
